rhythm_lane_core: RTL and testbench

- Parametrised game engine for the rhythm game: N_LANES note lanes, each LANE_LEN cells deep, driven from a SONG_LEN-step song pattern.
- Generates its own beat tick from a programmable period.
- Shifts notes toward the hit cell (index 0), judges button presses per lane, and keeps hit/miss/score/streak counts.
- Sits between the mode FSM / difficulty select and the LED and seven-segment display decoders. Replaces the fixed two-lane game core.

---
 rtl/rhythm_pkg.sv | 23 ++
 rtl/lane_shifter.sv | 41 ++++
 rtl/rhythm_lane_core.sv | 194 +++++++++++++++++++
 tb/tb_rhythm_lane_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types, constants and helpers for the rhythm game core.
package rhythm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    FINISH = 2'b11
  } state_t;

  // Streak (before the current hit) at which combo scoring starts.
  localparam int unsigned COMBO_THRESH = 4;

  // Add and clamp to lim; operands are counter-sized so the sum cannot wrap.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// One note lane: shift register toward the hit cell (cell 0), with note
// inject at the far end, hit-clear and per-lane judgement flags.
// LANE_LEN must be at least 2.
module lane_shifter
  import rhythm_pkg::*;
#(
  parameter int unsigned LANE_LEN = 7
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                shift,
  input  logic                inject,
  input  logic                press,
  output logic [LANE_LEN-1:0] cells,
  output logic                hit_c,
  output logic                miss_c
);

  logic [LANE_LEN-1:0] cells_q;

  // Judgement always uses the pre-shift hit cell; a pressed note is never
  // also reported as a shift-out miss.
  assign hit_c  = press & cells_q[0];
  assign miss_c = press ? ~cells_q[0] : (shift & cells_q[0]);
  assign cells  = cells_q;

  // Lane contents: clear wins, then beat shift (drops the old cell 0), then hit-clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cells_q <= '0;
    end else if (clear) begin
      cells_q <= '0;
    end else if (shift) begin
      cells_q <= {inject, cells_q[LANE_LEN-1:1]};
    end else if (hit_c) begin
      cells_q[0] <= 1'b0;
    end
  end

endmodule

// File: rtl/rhythm_lane_core.sv
// Rhythm game engine: beat divider, song stepping, game FSM and scoring.
// Optional build macro: COMBO_EN (hits score 2 once the streak reaches the
// combo threshold). start is honoured in every state so a game can be
// restarted directly; quit has priority over start, start over pause.
module rhythm_lane_core
  import rhythm_pkg::*;
#(
  parameter int unsigned N_LANES  = 2,
  parameter int unsigned LANE_LEN = 7,
  parameter int unsigned SONG_LEN = 32,
  parameter int unsigned PER_W    = 23,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         quit,
  input  logic [PER_W-1:0]             beat_period,
  input  logic [N_LANES*SONG_LEN-1:0]  song,
  input  logic [N_LANES-1:0]           press,
  output logic [N_LANES*LANE_LEN-1:0]  lane_disp,
  output logic [1:0]                   state,
  output logic                         beat,
  output logic                         hit,
  output logic                         miss,
  output logic [CNT_W-1:0]             score,
  output logic [CNT_W-1:0]             hits,
  output logic [CNT_W-1:0]             misses,
  output logic [CNT_W-1:0]             streak,
  output logic                         done
);

  localparam int unsigned STEP_W      = $clog2(SONG_LEN + 1);
  localparam int unsigned IDX_W       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int unsigned BEATS_TOTAL = SONG_LEN + LANE_LEN;
  localparam int unsigned BCNT_W      = $clog2(BEATS_TOTAL + 1);
  localparam int unsigned CNT_MAX     = 32'((64'(1) << CNT_W) - 64'(1));

  state_t                        state_q, state_d;
  logic [PER_W-1:0]              div_q, period_q;
  logic [N_LANES*SONG_LEN-1:0]   song_q;
  logic [STEP_W-1:0]             step_q;
  logic [BCNT_W-1:0]             bcnt_q;
  logic [CNT_W-1:0]              score_q, hits_q, misses_q, streak_q;
  logic                          beat_q, hit_q, miss_q, done_q;

  logic                          run_c, load_c, clear_c, beat_c, last_beat_c;
  logic [N_LANES-1:0]            press_c, inject_c, lane_hit_c, lane_miss_c;
  int unsigned                   n_hit_c, n_miss_c, pts_c;

  assign beat_c      = run_c && (div_q == period_q);
  assign last_beat_c = (bcnt_q == BCNT_W'(BEATS_TOTAL - 1));
  assign press_c     = press & {N_LANES{run_c}};

  // Game state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control: quit > start > pause > normal play.
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    load_c  = 1'b0;
    clear_c = 1'b0;
    if (quit) begin
      state_d = IDLE;
      clear_c = 1'b1;
    end else if (start) begin
      state_d = RUN;
      load_c  = 1'b1;
      clear_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            run_c = 1'b1;
            if ((div_q == period_q) && last_beat_c) state_d = FINISH;
          end
        end
        PAUSE:   if (pause) state_d = RUN;
        default: ;
      endcase
    end
  end

  // Beat divider, song latch, step index and beat count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q    <= '0;
      period_q <= '0;
      song_q   <= '0;
      step_q   <= '0;
      bcnt_q   <= '0;
    end else if (load_c) begin
      div_q    <= '0;
      period_q <= beat_period;
      song_q   <= song;
      step_q   <= '0;
      bcnt_q   <= '0;
    end else if (run_c) begin
      div_q <= beat_c ? '0 : div_q + PER_W'(1);
      if (beat_c) begin
        if (step_q < STEP_W'(SONG_LEN)) step_q <= step_q + STEP_W'(1);
        bcnt_q <= bcnt_q + BCNT_W'(1);
      end
    end
  end

  // One shifter per lane, fed from that lane's slice of the latched song.
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic [SONG_LEN-1:0] lane_song;
    assign lane_song   = song_q[l*SONG_LEN +: SONG_LEN];
    assign inject_c[l] = (step_q < STEP_W'(SONG_LEN)) ? lane_song[step_q[IDX_W-1:0]] : 1'b0;

    lane_shifter #(.LANE_LEN(LANE_LEN)) u_lane (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (clear_c),
      .shift  (beat_c),
      .inject (inject_c[l]),
      .press  (press_c[l]),
      .cells  (lane_disp[l*LANE_LEN +: LANE_LEN]),
      .hit_c  (lane_hit_c[l]),
      .miss_c (lane_miss_c[l])
    );
  end

  // Total hits and misses judged across all lanes this cycle.
  always_comb begin
    n_hit_c  = 0;
    n_miss_c = 0;
    for (int l = 0; l < N_LANES; l++) begin
      n_hit_c  = n_hit_c + 32'(lane_hit_c[l]);
      n_miss_c = n_miss_c + 32'(lane_miss_c[l]);
    end
  end

`ifdef COMBO_EN
  assign pts_c = (32'(streak_q) >= COMBO_THRESH) ? 2 * n_hit_c : n_hit_c;
`else
  assign pts_c = n_hit_c;
`endif

  // Saturating counters; any miss in a cycle zeroes the streak after that cycle's hits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      score_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      streak_q <= '0;
    end else if (load_c) begin
      score_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      streak_q <= '0;
    end else if (run_c) begin
      score_q  <= CNT_W'(sat_add(32'(score_q), pts_c, CNT_MAX));
      hits_q   <= CNT_W'(sat_add(32'(hits_q), n_hit_c, CNT_MAX));
      misses_q <= CNT_W'(sat_add(32'(misses_q), n_miss_c, CNT_MAX));
      streak_q <= (n_miss_c != 0) ? '0 : CNT_W'(sat_add(32'(streak_q), n_hit_c, CNT_MAX));
    end
  end

  // Registered event pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      beat_q <= 1'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      beat_q <= beat_c;
      hit_q  <= |lane_hit_c;
      miss_q <= |lane_miss_c;
      done_q <= beat_c && last_beat_c;
    end
  end

  assign state  = state_q;
  assign beat   = beat_q;
  assign hit    = hit_q;
  assign miss   = miss_q;
  assign done   = done_q;
  assign score  = score_q;
  assign hits   = hits_q;
  assign misses = misses_q;
  assign streak = streak_q;

endmodule

// File: tb/tb_rhythm_lane_core.sv
// Bench for rhythm_lane_core: game-level model plus directed scenarios.
module tb_rhythm_lane_core;

  localparam int unsigned NL  = 2;
  localparam int unsigned LL  = 7;
  localparam int unsigned SL  = 8;
  localparam int unsigned PW  = 23;
  localparam int unsigned CW  = 3;
  localparam int          MAXC = 7;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start, pause, quit;
  logic [PW-1:0]     beat_period;
  logic [NL*SL-1:0]  song;
  logic [NL-1:0]     press;
  logic [NL*LL-1:0]  lane_disp;
  logic [1:0]        state;
  logic              beat, hit, miss, done;
  logic [CW-1:0]     score, hits, misses, streak;

  int n_checks = 0;
  int n_pass   = 0;

  rhythm_lane_core #(
    .N_LANES(NL), .LANE_LEN(LL), .SONG_LEN(SL), .PER_W(PW), .CNT_W(CW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .quit(quit),
    .beat_period(beat_period), .song(song), .press(press),
    .lane_disp(lane_disp), .state(state), .beat(beat), .hit(hit), .miss(miss),
    .score(score), .hits(hits), .misses(misses), .streak(streak), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- game model ----------------
  int m_state, m_div, m_per, m_step, m_nb;
  int m_score, m_hits, m_miss, m_streak;
  bit m_beat, m_hit, m_missp, m_done;
  bit m_cell[NL][LL];
  logic [NL*SL-1:0] m_song;
  int nh, nm, pts;
  bit bt;

  function automatic int smin(input int a);
    return (a > MAXC) ? MAXC : a;
  endfunction

  function automatic logic [NL*LL-1:0] exp_disp();
    logic [NL*LL-1:0] v;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LL; c++) v[l*LL+c] = m_cell[l][c];
    return v;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_state = 0; m_div = 0; m_per = 0; m_step = 0; m_nb = 0; m_song = '0;
      m_score = 0; m_hits = 0; m_miss = 0; m_streak = 0;
      m_beat = 0; m_hit = 0; m_missp = 0; m_done = 0;
      for (int l = 0; l < NL; l++) for (int c = 0; c < LL; c++) m_cell[l][c] = 0;
    end else begin
      m_beat = 0; m_hit = 0; m_missp = 0; m_done = 0;
      if (quit) begin
        m_state = 0;
        for (int l = 0; l < NL; l++) for (int c = 0; c < LL; c++) m_cell[l][c] = 0;
      end else if (start) begin
        m_state = 1; m_div = 0; m_per = int'(beat_period); m_song = song;
        m_step = 0; m_nb = 0;
        m_score = 0; m_hits = 0; m_miss = 0; m_streak = 0;
        for (int l = 0; l < NL; l++) for (int c = 0; c < LL; c++) m_cell[l][c] = 0;
      end else if (m_state == 1 && pause) begin
        m_state = 2;
      end else if (m_state == 2 && pause) begin
        m_state = 1;
      end else if (m_state == 1) begin
        bt = (m_div == m_per);
        m_div = bt ? 0 : m_div + 1;
        nh = 0; nm = 0;
        for (int l = 0; l < NL; l++) begin
          if (press[l]) begin
            if (m_cell[l][0]) begin nh++; m_cell[l][0] = 0; end
            else nm++;
          end else if (bt && m_cell[l][0]) nm++;
          if (bt) begin
            for (int c = 0; c < LL-1; c++) m_cell[l][c] = m_cell[l][c+1];
            m_cell[l][LL-1] = (m_step < SL) ? m_song[l*SL+m_step] : 1'b0;
          end
        end
        if (bt) begin
          if (m_step < SL) m_step++;
          m_nb++;
          if (m_nb == SL + LL) begin m_state = 3; m_done = 1; end
        end
`ifdef COMBO_EN
        pts = (m_streak >= 4) ? 2*nh : nh;
`else
        pts = nh;
`endif
        m_score  = smin(m_score + pts);
        m_hits   = smin(m_hits + nh);
        m_miss   = smin(m_miss + nm);
        m_streak = (nm > 0) ? 0 : smin(m_streak + nh);
        m_beat = bt; m_hit = (nh > 0); m_missp = (nm > 0);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("state",     64'(state),     64'(m_state));
    chk("lane_disp", 64'(lane_disp), 64'(exp_disp()));
    chk("beat",      64'(beat),      64'(m_beat));
    chk("hit",       64'(hit),       64'(m_hit));
    chk("miss",      64'(miss),      64'(m_missp));
    chk("done",      64'(done),      64'(m_done));
    chk("score",     64'(score),     64'(m_score));
    chk("hits",      64'(hits),      64'(m_hits));
    chk("misses",    64'(misses),    64'(m_miss));
    chk("streak",    64'(streak),    64'(m_streak));
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic ctl(input bit s, input bit q, input bit p);
    start = s; quit = q; pause = p;
    @(negedge clk);
    start = 0; quit = 0; pause = 0;
  endtask

  // mode 0: no presses; 1: press every note; 2: once press both lanes on a beat with lane 0 note.
  task automatic run_game(input int mode, output int nb, output int gap);
    int t1, t2, fired;
    bit got;
    t1 = -1; t2 = -1; fired = -1; got = 0; nb = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fired >= 0 && i == fired + 1) begin
        chk("c_hit_pulse", 64'(hit), 64'd1);
        chk("c_miss_pulse", 64'(miss), 64'd1);
      end
      if (beat) begin
        nb++;
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
      if (done) begin got = 1; break; end
      press = '0;
      if (mode == 1) press = {m_cell[1][0], m_cell[0][0]};
      if (mode == 2 && fired < 0 && m_state == 1 && m_div == m_per && m_cell[0][0]) begin
        press = 2'b11; fired = i;
      end
    end
    press = '0;
    chk("done_seen", 64'(got), 64'd1);
    gap = t2 - t1;
  endtask

  int nb, gap;
  logic [NL*LL-1:0] snap;
  int beats_in_pause;

  initial begin
    n_rst = 0; start = 0; pause = 0; quit = 0; press = '0;
    beat_period = '0; song = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_disp",  64'(lane_disp), 64'd0);
    n_rst = 1;
    @(negedge clk);

    // A: lane 0 four notes, period 3, no presses.
    song = 16'h000F; beat_period = PW'(3);
    ctl(1, 0, 0);
    run_game(0, nb, gap);
    chk("a_beats", 64'(nb), 64'd15);
    chk("a_gap", 64'(gap), 64'd4);
    chk("a_misses", 64'(misses), 64'd4);
    chk("a_score", 64'(score), 64'd0);
    chk("a_state", 64'(state), 64'd3);

    // B: restart from FINISH and hit every note.
    ctl(1, 0, 0);
    run_game(1, nb, gap);
    chk("b_hits", 64'(hits), 64'd4);
    chk("b_misses", 64'(misses), 64'd0);
    chk("b_score", 64'(score), 64'd4);
    chk("b_streak", 64'(streak), 64'd4);

    // C: beat-coincident hit on lane 0 plus false press on lane 1.
    song = 16'h0001;
    ctl(1, 0, 0);
    run_game(2, nb, gap);
    chk("c_hits", 64'(hits), 64'd1);
    chk("c_misses", 64'(misses), 64'd1);
    chk("c_streak", 64'(streak), 64'd0);
    chk("c_score", 64'(score), 64'd1);

    // D: pause mid-song for 20 cycles; misses saturate at 7.
    song = 16'h00FF;
    ctl(1, 0, 0);
    repeat (30) @(negedge clk);
    ctl(0, 0, 1);
    snap = exp_disp();
    chk("d_paused", 64'(state), 64'd2);
    beats_in_pause = 0;
    repeat (20) begin
      @(negedge clk);
      press = 2'b11;
      if (beat) beats_in_pause++;
    end
    press = '0;
    chk("d_no_beat", 64'(beats_in_pause), 64'd0);
    chk("d_frozen", 64'(lane_disp), 64'(snap));
    ctl(0, 0, 1);
    run_game(0, nb, gap);
    chk("d_misses_sat", 64'(misses), 64'd7);

    // E: period 0, both lanes full, hit everything -> saturation.
    song = 16'hFFFF; beat_period = '0;
    ctl(1, 0, 0);
    run_game(1, nb, gap);
    chk("e_gap", 64'(gap), 64'd1);
    chk("e_hits", 64'(hits), 64'd7);
    chk("e_score", 64'(score), 64'd7);
    chk("e_streak", 64'(streak), 64'd7);
    chk("e_misses", 64'(misses), 64'd0);

    // F: quit during RUN keeps counters, then control priorities and restart.
    song = 16'h00FF; beat_period = PW'(1);
    ctl(1, 0, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      press = '0;
      if (m_hits >= 2) break;
      press = {1'b0, m_cell[0][0]};
    end
    press = '0;
    ctl(0, 1, 0);
    chk("f_idle", 64'(state), 64'd0);
    chk("f_clear", 64'(lane_disp), 64'd0);
    chk("f_hits_kept", 64'(hits), 64'd2);
    ctl(1, 1, 0);
    chk("f_quit_wins", 64'(state), 64'd0);
    ctl(1, 0, 1);
    chk("f_start_wins", 64'(state), 64'd1);
    chk("f_hits_zero", 64'(hits), 64'd0);
    run_game(0, nb, gap);
    chk("f_beats", 64'(nb), 64'd15);

    // G: asynchronous reset mid-game.
    ctl(1, 0, 0);
    repeat (20) @(negedge clk);
    #2 n_rst = 0;
    #1;
    chk("g_state", 64'(state), 64'd0);
    chk("g_disp", 64'(lane_disp), 64'd0);
    chk("g_misses", 64'(misses), 64'd0);
    @(negedge clk);
    n_rst = 1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
